// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction memory read port between
// the fetch unit (F) and the debug port (D), one read at a time.
module imem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req_valid,
    output logic                  f_req_ready,
    input  logic [ADDR_WIDTH-1:0] f_req_addr,
    input  logic                  f_flush,
    output logic                  f_resp_valid,
    input  logic                  f_resp_ready,
    output logic [DATA_WIDTH-1:0] f_resp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_resp_valid,
    input  logic                  d_resp_ready,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

    state_t                state_q;
    state_t                state_nx;
    logic                  owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            wait_q;

    logic d_pri;
    logic grant_f;
    logic grant_d;
    logic f_hs;
    logic d_hs;
    logic f_kill;
    logic f_done;
    logic d_done;

    // Arbitration, handshakes, flush and response channel decode
    always_comb begin
        d_pri   = wait_q >= 4'(MAX_WAIT);
        grant_d = d_req_valid && (!f_req_valid || d_pri);
        grant_f = f_req_valid && !grant_d;

        f_req_ready = rst_n && (state_q == IDLE) && grant_f;
        d_req_ready = rst_n && (state_q == IDLE) && grant_d;
        f_hs        = f_req_valid && f_req_ready;
        d_hs        = d_req_valid && d_req_ready;

        // A flush coinciding with a consumed response lets it complete.
        f_kill = !owner_q && f_flush
              && ((state_q == READ)
              || ((state_q == RESP) && !f_resp_ready));

        f_resp_valid = (state_q == RESP) && !owner_q && !f_kill;
        d_resp_valid = (state_q == RESP) && owner_q;
        f_resp_data  = f_resp_valid ? data_q : '0;
        d_resp_data  = d_resp_valid ? data_q : '0;

        f_done = f_resp_valid && f_resp_ready;
        d_done = d_resp_valid && d_resp_ready;

        mem_addr = addr_q;
        busy     = state_q != IDLE;
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            IDLE: if (f_hs || d_hs) state_nx = READ;
            READ: state_nx = f_kill ? IDLE : RESP;
            RESP: if (f_kill || f_done || d_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, request capture, read data capture and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_nx;
            if ((state_q == IDLE) && (f_hs || d_hs)) begin
                owner_q <= d_hs;
                addr_q  <= d_hs
                         ? {d_req_addr[ADDR_WIDTH-1:2], 2'b00}
                         : {f_req_addr[ADDR_WIDTH-1:2], 2'b00};
                if (d_hs) begin
                    wait_q <= '0;
                end else if (d_req_valid && (wait_q != 4'hF)) begin
                    wait_q <= wait_q + 4'd1;
                end
            end
            if ((state_q == READ) && !f_kill) begin
                data_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter with a
// transaction-level reference model and randomized traffic.
module tb_imem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          f_req_valid  = 1'b0;
    logic          f_req_ready;
    logic [AW-1:0] f_req_addr   = '0;
    logic          f_flush      = 1'b0;
    logic          f_resp_valid;
    logic          f_resp_ready = 1'b1;
    logic [DW-1:0] f_resp_data;
    logic          d_req_valid  = 1'b0;
    logic          d_req_ready;
    logic [AW-1:0] d_req_addr   = '0;
    logic          d_resp_valid;
    logic          d_resp_ready = 1'b1;
    logic [DW-1:0] d_resp_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    logic [31:0] mem [8] = '{
        32'h00000013, 32'h00400093, 32'h00C00113, 32'h002081B3,
        32'h00312023, 32'h00008067, 32'hDEADBEEF, 32'hCAFEF00D
    };

    // Memory aliases every 32 bytes; the arbiter never range-checks.
    assign mem_rdata = mem[mem_addr[4:2]];

    imem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req_valid (f_req_valid),
        .f_req_ready (f_req_ready),
        .f_req_addr  (f_req_addr),
        .f_flush     (f_flush),
        .f_resp_valid(f_resp_valid),
        .f_resp_ready(f_resp_ready),
        .f_resp_data (f_resp_data),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_addr  (d_req_addr),
        .d_resp_valid(d_resp_valid),
        .d_resp_ready(d_resp_ready),
        .d_resp_data (d_resp_data),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } txn_t;

    txn_t        f_q[$];
    txn_t        d_q[$];
    int          cycle     = 0;
    int          n_chk     = 0;
    int          n_fail    = 0;
    int          lost      = 0;
    logic [31:0] last_addr = '0;
    logic        f_acc     = 1'b0;
    logic        d_acc     = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     nm, act, exp, cycle);
        end
    endtask

    // Reference model: one read in flight, F priority unless D has
    // lost MW arbitrations in a row; pushes expected responses.
    always @(negedge clk) begin : model
        logic inflight;
        logic ef;
        logic ed;
        f_acc = 1'b0;
        d_acc = 1'b0;
        if (rst_n) begin
            inflight = (f_q.size() + d_q.size()) != 0;
            ed = !inflight && d_req_valid
              && (!f_req_valid || lost >= MW);
            ef = !inflight && f_req_valid && !ed;
            chk("f_req_ready", 32'(f_req_ready), 32'(ef));
            chk("d_req_ready", 32'(d_req_ready), 32'(ed));
            chk("busy", 32'(busy), 32'(inflight));
            chk("mem_addr", mem_addr, last_addr);
            if (ef) begin
                f_q.push_back('{data: mem[f_req_addr[4:2]],
                                acc: cycle});
                last_addr = f_req_addr & ~32'h3;
                if (d_req_valid && lost < 15) lost++;
                f_acc = 1'b1;
            end
            if (ed) begin
                d_q.push_back('{data: mem[d_req_addr[4:2]],
                                acc: cycle});
                last_addr = d_req_addr & ~32'h3;
                lost  = 0;
                d_acc = 1'b1;
            end
        end
    end

    task automatic mon(input bit is_d);
        txn_t        t;
        int          age;
        int          n;
        logic        v;
        logic        r;
        logic        fl;
        logic [31:0] dat;
        string       pn;
        pn  = is_d ? "d" : "f";
        v   = is_d ? d_resp_valid : f_resp_valid;
        r   = is_d ? d_resp_ready : f_resp_ready;
        dat = is_d ? d_resp_data : f_resp_data;
        fl  = !is_d && f_flush;
        n   = is_d ? d_q.size() : f_q.size();
        if (n == 0) begin
            chk({pn, "_resp_valid unexpected"}, 32'(v), 32'(0));
            return;
        end
        t   = is_d ? d_q[0] : f_q[0];
        age = cycle - t.acc;
        if (age < 2) begin
            chk({pn, "_resp_valid early"}, 32'(v), 32'(0));
        end else begin
            chk({pn, "_resp_valid"}, 32'(v), 32'(!(fl && !r)));
            if (v) chk({pn, "_resp_data"}, dat, t.data);
        end
        if ((age >= 2 && v && r)
            || (fl && age >= 1 && !(age >= 2 && r))) begin
            if (is_d) void'(d_q.pop_front());
            else      void'(f_q.pop_front());
        end
    endtask

    // Response monitor, sampled just after the model each cycle
    always @(negedge clk) begin : monitor
        #1;
        if (rst_n) begin
            mon(1'b0);
            mon(1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input bit is_d);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(is_d ? d_acc : f_acc) && k < 60);
        if (k >= 60) chk("accept timeout", 32'(0), 32'(1));
    endtask

    task automatic issue(input bit is_d, input logic [31:0] a);
        if (is_d) begin
            d_req_valid = 1'b1;
            d_req_addr  = a;
        end else begin
            f_req_valid = 1'b1;
            f_req_addr  = a;
        end
        wait_acc(is_d);
        if (is_d) d_req_valid = 1'b0;
        else      f_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((f_q.size() + d_q.size()) != 0 && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) chk("idle timeout", 32'(0), 32'(1));
        tick();
    endtask

    initial begin
        int nf;
        int k;
        // Reset: readys gated even with a valid present
        f_req_valid = 1'b1;
        #1;
        chk("rst f_req_ready", 32'(f_req_ready), 32'(0));
        chk("rst d_req_ready", 32'(d_req_ready), 32'(0));
        chk("rst f_resp_valid", 32'(f_resp_valid), 32'(0));
        chk("rst d_resp_valid", 32'(d_resp_valid), 32'(0));
        chk("rst f_resp_data", f_resp_data, 32'(0));
        chk("rst d_resp_data", d_resp_data, 32'(0));
        chk("rst mem_addr", mem_addr, 32'(0));
        chk("rst busy", 32'(busy), 32'(0));
        f_req_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single fetch, 2-cycle latency
        issue(1'b0, 32'h4);
        wait_idle();

        // Contention: four F wins, then D is promoted, twice
        f_req_valid = 1'b1;
        f_req_addr  = 32'h8;
        for (int rnd = 0; rnd < 2; rnd++) begin
            d_req_valid = 1'b1;
            d_req_addr  = 32'hC;
            nf = 0;
            k  = 0;
            do begin
                tick();
                k++;
                if (f_acc) nf++;
            end while (!d_acc && k < 60);
            d_req_valid = 1'b0;
            chk("f grants before d", 32'(nf), 32'(4));
        end
        f_req_valid = 1'b0;
        wait_idle();

        // Back-pressured fetch response held, D kept waiting
        f_resp_ready = 1'b0;
        issue(1'b0, 32'h10);
        tick();
        d_req_valid = 1'b1;
        d_req_addr  = 32'h0;
        repeat (5) tick();
        f_resp_ready = 1'b1;
        wait_acc(1'b1);
        d_req_valid = 1'b0;
        wait_idle();

        // Misaligned debug read and last preloaded word
        issue(1'b1, 32'h3);
        wait_idle();
        issue(1'b0, 32'h14);
        wait_idle();

        // Flush in READ of a fetch, then a normal fetch
        issue(1'b0, 32'h4);
        f_flush = 1'b1;
        tick();
        f_flush = 1'b0;
        chk("flush busy", 32'(busy), 32'(0));
        chk("flush f_resp_valid", 32'(f_resp_valid), 32'(0));
        wait_idle();
        issue(1'b0, 32'h0);
        wait_idle();

        // Flush during a debug read has no effect
        issue(1'b1, 32'h8);
        f_flush = 1'b1;
        tick();
        tick();
        f_flush = 1'b0;
        wait_idle();

        // Asynchronous reset while in RESP
        f_resp_ready = 1'b0;
        issue(1'b0, 32'h4);
        tick();
        d_req_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst f_resp_valid", 32'(f_resp_valid), 32'(0));
        chk("arst d_resp_valid", 32'(d_resp_valid), 32'(0));
        chk("arst f_req_ready", 32'(f_req_ready), 32'(0));
        chk("arst d_req_ready", 32'(d_req_ready), 32'(0));
        chk("arst busy", 32'(busy), 32'(0));
        chk("arst mem_addr", mem_addr, 32'(0));
        f_q.delete();
        d_q.delete();
        lost        = 0;
        last_addr   = '0;
        d_req_valid = 1'b0;
        f_resp_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        issue(1'b0, 32'hC);
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (f_acc || !f_req_valid) begin
                f_req_valid = ($urandom % 3) == 0;
                f_req_addr  = $urandom_range(0, 63);
            end
            if (d_acc || !d_req_valid) begin
                d_req_valid = ($urandom % 3) == 0;
                d_req_addr  = $urandom_range(0, 63);
            end
            f_resp_ready = ($urandom % 4) != 0;
            d_resp_ready = ($urandom % 4) != 0;
            f_flush      = ($urandom % 10) == 0;
            tick();
        end
        f_req_valid  = 1'b0;
        d_req_valid  = 1'b0;
        f_flush      = 1'b0;
        f_resp_ready = 1'b1;
        d_resp_ready = 1'b1;
        wait_idle();

        chk("pending f", 32'(f_q.size()), 32'(0));
        chk("pending d", 32'(d_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational read port of the instruction memory between two requesters: the core fetch unit (port F) and the debug/program-inspection port (port D).
- Each requester uses valid/ready handshakes; one transaction is in flight at a time.
- Read data is registered and returned on per-port response channels.
- Sits between the PC/fetch logic and the instruction memory. Implements fixed priority for F, with anti-starvation promotion for D and fetch-flush cancellation.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, instruction word width.
- MAX_WAIT, 4, consecutive lost arbitrations after which D wins the next arbitration; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req_valid  in  1  fetch request valid.
- f_req_ready  out  1  fetch request accepted this cycle when high with valid.
- f_req_addr  in  ADDR_WIDTH  fetch byte address.
- f_flush  in  1  cancel the in-flight fetch transaction (branch redirect).
- f_resp_valid  out  1  fetch response valid.
- f_resp_ready  in  1  fetch response consumed.
- f_resp_data  out  DATA_WIDTH  fetched instruction.
- d_req_valid / d_req_ready / d_req_addr: debug request channel, same rules as the F request channel.
- d_resp_valid / d_resp_ready / d_resp_data: debug response channel, same rules as the F response channel.
- mem_addr  out  ADDR_WIDTH  address to the instruction memory; low 2 bits are forced to 0.
- mem_rdata  in  DATA_WIDTH  combinational memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, all ready and valid outputs 0, resp_data=0, mem_addr=0, owner=F, wait_cnt=0.
- Reset asserted mid-transaction aborts it immediately; no response is ever issued for it.
- States are IDLE, READ and RESP.
- IDLE:
  - Grant is combinational from the valids. If only one requester is valid, it wins.
  - If both are valid: D wins when wait_cnt >= MAX_WAIT, else F wins.
  - Only the winner's req_ready is high; both readys are 0 when neither requester is valid. A ready depending on the same-cycle valid is intentional.
  - On handshake: latch the address with bits [1:0] cleared into addr_q, latch owner, go to READ.
- READ:
  - mem_addr=addr_q.
  - At the clock edge, capture mem_rdata into data_q and go to RESP.
- RESP:
  - Owner's resp_valid=1 and resp_data=data_q. The other port's resp_valid=0.
  - resp_valid and resp_data stay stable until resp_ready is high; the handshake edge returns the block to IDLE.
  - Latency: accept at edge N, resp_valid high from the cycle after edge N+1, i.e. the 2nd cycle after acceptance.
  - Maximum throughput: 1 transaction per 3 cycles.
- mem_addr holds addr_q in all states. It is 0 only after reset until the first accept.
- wait_cnt counts D starvation:
  - Increments (saturating at 15) on each IDLE handshake granted to F while d_req_valid=1.
  - Clears on any D grant.
  - Unchanged otherwise.
- f_flush:
  - If asserted while owner=F and state is READ or RESP, go to IDLE at the next edge and drop the response. f_resp_valid is forced to 0 in that cycle and never raised for this transaction.
  - Ignored when owner=D or in IDLE.
  - A flush in the same cycle as the f_resp handshake: the handshake completes and the flush has no extra effect.
- A requester must hold valid and addr stable until ready; a withdrawn valid in IDLE simply re-arbitrates the next cycle.
- Misaligned addresses are aligned silently (0x3 reads word 0x0).
- Addresses beyond the memory return whatever the memory returns; the block does not range-check.

Test Plan:
- Memory model preloaded with 0x00000013, 0x00400093, 0x00C00113, 0x002081B3, 0x00312023, 0x00008067 at byte addresses 0x0..0x14.
- F only, addr 0x4, f_resp_ready=1 -> f_req_ready high in the request cycle; f_resp_valid is high exactly 2 cycles after accept with data 0x00400093; busy high for 2 cycles.
- F and D both valid continuously, F addr 0x8, D addr 0xC -> F is granted 4 times (data 0x00C00113 each time), the 5th grant goes to D (data 0x002081B3), and wait_cnt returns to 0.
- F request at addr 0x10 with f_resp_ready=0 for 5 cycles -> f_resp_valid and data 0x00312023 held stable for all 5 cycles; no new request is accepted; IDLE resumes after the handshake.
- D addr 0x3 -> d_resp_data 0x00000013 and mem_addr 0x0. F addr 0x14 -> 0x00008067.
- f_flush pulsed in READ of an F transaction to 0x4 -> no f_resp_valid, back in IDLE next cycle, a following F request to 0x0 returns 0x00000013. Also pulse f_flush during a D transaction -> D response still delivered.
- rst_n dropped asynchronously in RESP -> all valid and ready outputs 0 immediately, busy=0; after release a new F request to 0xC returns 0x002081B3.
